mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter NUM_W, default 5, register-number width.
REQ-002 Parameter DATA_W, default 32, datapath width; only 32 is supported for load formatting.
REQ-003 Parameter CNT_W, default 32, retire-counter width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 stall_in  in  1  hold all state this cycle.
REQ-008 flush_in  in  1  kill the entry being captured.
REQ-009 valid_in  in  1  MEM-stage entry valid.
REQ-010 wr_num_in  in  NUM_W  destination register.
REQ-011 reg_write_in  in  1  entry writes the register file.
REQ-012 reg_wr_src_in  in  2  00 ALU, 01 PC+4, 10 memory load, 11 immediate.
REQ-013 ALU_result_in / pc_plus4_in / imm_in / memory_data_in  in  DATA_W each  writeback candidates.
REQ-014 ld_funct3_in  in  3  load size/sign; addr_low_in  in  2  load address bits [1:0].
REQ-015 misalign_clr_in  in  1  clear sticky misalign flag.
REQ-016 valid_out  out  1; wr_num_out  out  NUM_W; reg_write_out  out  1; wr_data_out  out  DATA_W; misalign_out  out  1 (sticky); retire_cnt_out  out  CNT_W. All outputs registered.

Function
REQ-017 Capture condition: rising clk with stall_in=0 and flush_in=0; all output registers load next values with one-cycle latency.
REQ-018 stall_in=1 with flush_in=0: every output and the counter hold.
REQ-019 flush_in=1 (wins over stall_in): valid_out<=0, reg_write_out<=0; wr_num_out, wr_data_out hold; counter holds.
REQ-020 Source select: 00 ALU_result_in, 01 pc_plus4_in, 11 imm_in, 10 formatted load data.
REQ-021 Load formatting, byte B = memory_data_in[8*addr_low_in+7 : 8*addr_low_in], half H = addr_low_in[1] ? bits[31:16] : bits[15:0].
REQ-022 funct3 000 sign-extend B; 100 zero-extend B; 001 sign-extend H; 101 zero-extend H; 010 and all other codes full word.
REQ-023 Misaligned load: src=10, valid_in=1, and (half with addr_low_in[0]=1, or word with addr_low_in!=00).
REQ-024 On captured misaligned load: misalign_out<=1, reg_write_out<=0, wr_data_out<=0.
REQ-025 reg_write_out <= reg_write_in AND valid_in AND (wr_num_in != 0) AND NOT misaligned.
REQ-026 valid_out <= valid_in on capture, including for misaligned loads.
REQ-027 retire_cnt_out increments by 1 on each capture with valid_in=1 (misaligned included); wraps modulo 2^CNT_W.
REQ-028 misalign_clr_in clears misalign_out on any edge, stall or not; simultaneous new misalign capture wins (flag stays 1).
REQ-029 valid_in=0 capture: valid_out=0, reg_write_out=0, wr_num_out/wr_data_out load inputs normally, no misalign set.

Reset
REQ-030 rst_n=0 SHALL immediately force valid_out, wr_num_out, reg_write_out, wr_data_out, misalign_out, retire_cnt_out to 0, independent of clk.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; first capture after release behaves per REQ-017.

Verification
REQ-032 src=10, funct3=000, addr=11, mem=0x80FF_1234 -> next cycle wr_data_out=0xFFFF_FF80, reg_write_out=1.
REQ-033 src=10, funct3=101, addr=10, mem=0x80FF_1234 -> wr_data_out=0x0000_80FF; funct3=001 same -> 0xFFFF_80FF.
REQ-034 src=10, funct3=010, addr=01, reg_write_in=1 -> reg_write_out=0, wr_data_out=0, misalign_out=1 sticky until misalign_clr_in; clr with new misalign same cycle -> stays 1.
REQ-035 wr_num_in=0, reg_write_in=1, src=00 ALU=0x1234 -> wr_data_out=0x1234, reg_write_out=0, counter +1.
REQ-036 Stall 3 cycles then flush with stall still high -> outputs hold 3 cycles, then valid_out=0, reg_write_out=0, counter unchanged.
REQ-037 CNT_W=4, 17 valid captures -> retire_cnt_out=1; async rst_n pulse between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register of a RISC-V style core. Selects the writeback
//   value (ALU, PC+4, immediate or formatted load data), formats sub-word
//   loads, detects misaligned loads, and counts retired (valid) entries.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_in            : hold every register this cycle
//   flush_in            : kill the entry being captured (wins over stall)
//   valid_in            : MEM-stage entry valid
//   wr_num_in           : destination register number
//   reg_write_in        : entry writes the register file
//   reg_wr_src_in       : 00 ALU, 01 PC+4, 10 load, 11 immediate
//   ALU_result_in, pc_plus4_in, imm_in, memory_data_in : writeback candidates
//   ld_funct3_in        : load size / sign
//   addr_low_in         : load address bits [1:0]
//   misalign_clr_in     : clear the sticky misalign flag
//   valid_out, wr_num_out, reg_write_out, wr_data_out   : registered WB entry
//   misalign_out        : sticky misaligned-load flag
//   retire_cnt_out      : count of captured valid entries (wraps)
// Load formatting assumes DATA_W = 32.
// ----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int NUM_W  = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic              valid_in,
   input  logic [NUM_W-1:0]  wr_num_in,
   input  logic              reg_write_in,
   input  logic [1:0]        reg_wr_src_in,
   input  logic [DATA_W-1:0] ALU_result_in,
   input  logic [DATA_W-1:0] pc_plus4_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [DATA_W-1:0] memory_data_in,
   input  logic [2:0]        ld_funct3_in,
   input  logic [1:0]        addr_low_in,
   input  logic              misalign_clr_in,
   output logic              valid_out,
   output logic [NUM_W-1:0]  wr_num_out,
   output logic              reg_write_out,
   output logic [DATA_W-1:0] wr_data_out,
   output logic              misalign_out,
   output logic [CNT_W-1:0]  retire_cnt_out
);

   logic              valid_q, valid_d;
   logic [NUM_W-1:0]  wr_num_q, wr_num_d;
   logic              reg_write_q, reg_write_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              misalign_q, misalign_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

   // Byte lanes of the loaded word, indexed by address low bits.
   logic [7:0] lane [4];
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = memory_data_in[8*gi +: 8];
      end
   endgenerate

   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] sel_data;
   logic              is_byte, is_half, is_word;
   logic              misaligned;
   logic              capture;

   always_comb begin
      byte_sel = lane[addr_low_in];
      half_sel = addr_low_in[1] ? memory_data_in[31:16] : memory_data_in[15:0];

      case (ld_funct3_in)
         3'b000:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
         3'b001:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
         default: load_data = memory_data_in;
      endcase

      // Any funct3 that is not a byte or half access is treated as a word.
      is_byte = (ld_funct3_in == 3'b000) || (ld_funct3_in == 3'b100);
      is_half = (ld_funct3_in == 3'b001) || (ld_funct3_in == 3'b101);
      is_word = !(is_byte || is_half);

      misaligned = valid_in && (reg_wr_src_in == 2'b10) &&
                   ((is_half && addr_low_in[0]) ||
                    (is_word && (addr_low_in != 2'b00)));

      case (reg_wr_src_in)
         2'b00:   sel_data = ALU_result_in;
         2'b01:   sel_data = pc_plus4_in;
         2'b10:   sel_data = load_data;
         default: sel_data = imm_in;
      endcase

      capture = !stall_in && !flush_in;

      valid_d      = valid_q;
      wr_num_d     = wr_num_q;
      reg_write_d  = reg_write_q;
      wr_data_d    = wr_data_q;
      retire_cnt_d = retire_cnt_q;

      if (flush_in) begin
         // Kill the entry but leave number/data as they were.
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
      end else if (capture) begin
         valid_d     = valid_in;
         wr_num_d    = wr_num_in;
         reg_write_d = reg_write_in && valid_in && (wr_num_in != '0) && !misaligned;
         wr_data_d   = misaligned ? '0 : sel_data;
         if (valid_in) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
         end
      end

      // Clear acts on every edge; a new misaligned capture takes priority.
      if (capture && misaligned) begin
         misalign_d = 1'b1;
      end else if (misalign_clr_in) begin
         misalign_d = 1'b0;
      end else begin
         misalign_d = misalign_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         wr_num_q     <= '0;
         reg_write_q  <= 1'b0;
         wr_data_q    <= '0;
         misalign_q   <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         wr_num_q     <= wr_num_d;
         reg_write_q  <= reg_write_d;
         wr_data_q    <= wr_data_d;
         misalign_q   <= misalign_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign valid_out      = valid_q;
   assign wr_num_out     = wr_num_q;
   assign reg_write_out  = reg_write_q;
   assign wr_data_out    = wr_data_q;
   assign misalign_out   = misalign_q;
   assign retire_cnt_out = retire_cnt_q;

endmodule
